// File: rtl/regfile_mp_pkg.sv
// Shared defaults and display-scan state encoding for the multi-port register file.
package regfile_mp_pkg;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_LINK_REG = 31;
  localparam int DEF_SCAN_DIV = 4;

  typedef enum logic {
    ST_STATIC = 1'b0,
    ST_SCAN   = 1'b1
  } scan_state_t;
endpackage

// File: rtl/regfile_scan.sv
// Display index sequencer: static select or divided auto-scan through all registers.
module regfile_scan
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dsp_mode,
  input  logic [ADDR_W-1:0] dsp_sel,
  output logic [ADDR_W-1:0] dsp_idx
);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  scan_state_t      state;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_base;

  // A fresh entry into SCAN always counts from zero, whatever the divider holds.
  assign div_base = (state == ST_SCAN) ? div : '0;

  // Mode select, divider and display index update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_STATIC;
      div     <= '0;
      dsp_idx <= '0;
    end else if (!dsp_mode) begin
      state   <= ST_STATIC;
      div     <= '0;
      dsp_idx <= dsp_sel;
    end else begin
      state <= ST_SCAN;
      if (div_base == DIV_LAST) begin
        div     <= '0;
        dsp_idx <= dsp_idx + ADDR_W'(1);
      end else begin
        div     <= div_base + DIV_W'(1);
      end
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with jal link write, reservation tracking and a
// scanned debug display port.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int LINK_REG = DEF_LINK_REG,
  parameter int SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     Reg_wr,
  input  logic [ADDR_W-1:0]        w_addr,
  input  logic [DATA_W-1:0]        w_data,
  input  logic                     jal,
  input  logic [DATA_W-1:0]        link_data,
  input  logic                     rsv_valid,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     dsp_mode,
  input  logic [ADDR_W-1:0]        dsp_sel,
  output logic [ADDR_W-1:0]        dsp_idx,
  output logic [DATA_W-1:0]        displaydata,
  output logic                     wr_conflict
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_next;

  logic              eff_we;
  logic [ADDR_W-1:0] eff_addr;
  logic [DATA_W-1:0] eff_data;
  logic              rsv_set;

  // jal wins over Reg_wr; register 0 is never a write or reservation target.
  assign eff_addr = jal ? LINK_ADDR : w_addr;
  assign eff_data = jal ? link_data : w_data;
  assign eff_we   = !rst && (jal || Reg_wr) && (eff_addr != '0);
  assign rsv_set  = !rst && rsv_valid && (rsv_addr != '0);

  // Pending bits: a reservation overrides a same-cycle clearing write.
  always_comb begin
    pend_next = pend;
    if (eff_we) begin
      pend_next[eff_addr] = 1'b0;
    end else begin
      pend_next = pend;
    end
    if (rsv_set) begin
      pend_next[rsv_addr] = 1'b1;
    end else begin
      pend_next[0] = 1'b0;
    end
  end

  // Register array, pending bits and dropped-write flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      pend        <= '0;
      wr_conflict <= 1'b0;
    end else begin
      if (eff_we) begin
        regs[eff_addr] <= eff_data;
      end
      pend        <= pend_next;
      wr_conflict <= jal && Reg_wr && (w_addr != LINK_ADDR) && (w_addr != '0);
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              clr_hit;
    logic              set_hit;

    assign a       = rd_addr[k*ADDR_W +: ADDR_W];
    assign clr_hit = eff_we && (eff_addr == a);
    assign set_hit = rsv_set && (rsv_addr == a);

    assign rd_data[k*DATA_W +: DATA_W] = (a == '0) ? '0 :
                                         clr_hit   ? eff_data : regs[a];
    assign rd_pending[k] = !rst && pend[a] && !(clr_hit && !set_hit);
  end

  regfile_scan #(
    .ADDR_W   (ADDR_W),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .dsp_mode (dsp_mode),
    .dsp_sel  (dsp_sel),
    .dsp_idx  (dsp_idx)
  );

  // Display path deliberately shows committed contents only.
  assign displaydata = regs[dsp_idx];
endmodule
